system_pll_reset_seq: RTL

SYSTEM_PLL_RESET_SEQ -- requirements
Module: system_pll_reset_seq

---
 rtl/soc_system_clk_pkg.sv | 22 ++
 rtl/soc_system_sync_bit.sv | 24 ++
 rtl/system_pll_reset_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/soc_system_clk_pkg.sv
// Shared definitions for the system clock/reset sequencer: FSM state encoding
// and the sizing rule for its cycle counters.
package soc_system_clk_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  // Width of one counter able to hold the largest of the three phase lengths.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/soc_system_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module soc_system_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/system_pll_reset_seq.sv
// PLL reset / lock sequencer: pulses the PLL reset, waits for a stable lock with
// bounded retries, then releases the system reset; re-sequences on lock loss.
module system_pll_reset_seq
  import soc_system_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_lost_count
);

  localparam int CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  seq_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic [7:0]         lost_nxt;
  logic               locked_s;

  soc_system_sync_bit u_sync_locked (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost_count;
    case (state)
      ST_PLL_RST: begin
        if (cnt == PLL_RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt = '0;
          if (retry_cnt == RETRY_LIMIT) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_PLL_RST;
            retry_nxt = retry_cnt + RETRY_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A single low sample drops back to waiting without spending a retry.
        if (!locked_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        retry_nxt = '0;
        if (!locked_s) begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
          if (lock_lost_count != 8'hFF) lost_nxt = lock_lost_count + 8'd1;
        end
      end
      ST_FAIL: begin
        state_nxt = ST_FAIL;
      end
      default: begin
        state_nxt = ST_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= ST_PLL_RST;
      cnt             <= '0;
      retry_cnt       <= '0;
      lock_lost_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry_cnt       <= retry_nxt;
      lock_lost_count <= lost_nxt;
      pll_rst         <= (state_nxt == ST_PLL_RST);
      sys_rst         <= (state_nxt != ST_RUN);
      ready           <= (state_nxt == ST_RUN);
      fail            <= (state_nxt == ST_FAIL);
    end
  end

endmodule
